// File: rtl/bcd_result_display.sv
// Captures a 3-digit BCD sum on a rising load edge and shows it on three 7-segment displays.
// Optional macro BCD_DISP_LZB_EN enables leading-zero blanking of the tens and hundreds digits.
module bcd_result_display #(
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [8:0] vec_to_decimal,
    input  logic       load,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic       valid,
    output logic       err
);

    localparam int unsigned CntW = $clog2(BLINK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);

    localparam logic [6:0] SegBlank = 7'h7F;
    localparam logic [6:0] SegE     = 7'b0000110;

    typedef enum logic [1:0] {StBlank, StShow, StError} state_e;

    state_e          state_q, state_d;
    logic            load_q;
    logic [8:0]      held_q, held_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            blink_q, blink_d;
    logic [6:0]      hex0_d, hex1_d, hex2_d;
    logic            valid_d, err_d;
    logic            capture;
    logic            bad_digit;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    assign capture   = load & ~load_q;
    assign bad_digit = (vec_to_decimal[7:4] > 4'd9) || (vec_to_decimal[3:0] > 4'd9);

    // Next state, held value and blink timer; any capture restarts the blink phase.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        cnt_d   = '0;
        blink_d = 1'b0;
        if (capture) begin
            held_d = vec_to_decimal;
            if (bad_digit) begin
                state_d = StError;
                blink_d = 1'b1;
            end else begin
                state_d = StShow;
            end
        end else if (state_q == StError) begin
            blink_d = blink_q;
            if (cnt_q == CntMax) begin
                cnt_d   = '0;
                blink_d = ~blink_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Display decode from registered state only, so outputs never see the inputs directly.
    always_comb begin
        hex0_d  = SegBlank;
        hex1_d  = SegBlank;
        hex2_d  = SegBlank;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StShow: begin
                hex0_d  = seg7(held_q[3:0]);
                hex1_d  = seg7(held_q[7:4]);
                hex2_d  = held_q[8] ? seg7(4'd1) : seg7(4'd0);
                valid_d = 1'b1;
`ifdef BCD_DISP_LZB_EN
                if (!held_q[8]) begin
                    hex2_d = SegBlank;
                    if (held_q[7:4] == 4'd0) begin
                        hex1_d = SegBlank;
                    end
                end
`endif
            end
            StError: begin
                hex0_d = SegE;
                err_d  = blink_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q <= StBlank;
            held_q  <= '0;
            load_q  <= 1'b1;
            cnt_q   <= '0;
            blink_q <= 1'b0;
            HEX0    <= SegBlank;
            HEX1    <= SegBlank;
            HEX2    <= SegBlank;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            load_q  <= load;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
            HEX0    <= hex0_d;
            HEX1    <= hex1_d;
            HEX2    <= hex2_d;
            valid   <= valid_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_bcd_result_display.sv
// Scoreboard bench for bcd_result_display with a short blink period; honours BCD_DISP_LZB_EN.
module tb_bcd_result_display;

    localparam int unsigned BlinkDiv = 4;
    localparam logic [6:0] Blank = 7'h7F;
    localparam logic [6:0] SegE  = 7'b0000110;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [8:0] vec;
    logic       load;
    logic [6:0] HEX0, HEX1, HEX2;
    logic       valid, err;

    typedef struct {
        logic [6:0] h2;
        logic [6:0] h1;
        logic [6:0] h0;
        logic       v;
        logic       e;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bcd_result_display #(
        .BLINK_DIV(BlinkDiv)
    ) dut (
        .CLOCK_50      (clk),
        .reset_n       (reset_n),
        .vec_to_decimal(vec),
        .load          (load),
        .HEX0          (HEX0),
        .HEX1          (HEX1),
        .HEX2          (HEX2),
        .valid         (valid),
        .err           (err)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_exp(logic [6:0] h2, logic [6:0] h1, logic [6:0] h0,
                                     logic v, logic e, string name);
        exp_t x;
        x.h2 = h2; x.h1 = h1; x.h0 = h0; x.v = v; x.e = e; x.name = name;
        sb.push_back(x);
    endfunction

    function automatic void push_show(logic [8:0] d, string name);
        logic [6:0] h2, h1;
        h2 = d[8] ? seg_tab[1] : seg_tab[0];
        h1 = seg_tab[d[7:4]];
`ifdef BCD_DISP_LZB_EN
        if (!d[8]) h2 = Blank;
        if (!d[8] && d[7:4] == 4'd0) h1 = Blank;
`endif
        push_exp(h2, h1, seg_tab[d[3:0]], 1'b1, 1'b0, name);
    endfunction

    task automatic test_reset();
        exp_t x;
        reset_n = 1'b0;
        load    = 1'b1;
        vec     = 9'h123;
        push_exp(Blank, Blank, Blank, 1'b0, 1'b0, "reset_hold");
        step();
        step();
        // Release with load still high: no capture may follow.
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) push_exp(Blank, Blank, Blank, 1'b0, 1'b0, "reset_release");
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            x = sb.pop_front();
            n_checks++;
            if ({HEX2, HEX1, HEX0, valid, err} !== {x.h2, x.h1, x.h0, x.v, x.e})
                $display("FAIL %s[%0d]: got h2=%b h1=%b h0=%b v=%b e=%b want h2=%b h1=%b h0=%b v=%b e=%b",
                         x.name, i, HEX2, HEX1, HEX0, valid, err, x.h2, x.h1, x.h0, x.v, x.e);
            if ({HEX2, HEX1, HEX0, valid, err} !== {x.h2, x.h1, x.h0, x.v, x.e}) n_fail++;
        end
    endtask

    task automatic test_show();
        exp_t x;
        logic [8:0] tab [7] = '{9'h198, 9'h005, 9'h000, 9'h109, 9'h050, 9'h087, 9'h100};
        load = 1'b0;
        step();
        for (int i = 0; i < 7; i++) begin
            vec  = tab[i];
            load = 1'b1;
            if (i == 0) begin
                push_exp(7'b1111001, 7'b0010000, 7'b0000000, 1'b1, 1'b0, "show_198");
            end else if (i == 1) begin
`ifdef BCD_DISP_LZB_EN
                push_exp(Blank, Blank, 7'b0010010, 1'b1, 1'b0, "show_005");
`else
                push_exp(7'b1000000, 7'b1000000, 7'b0010010, 1'b1, 1'b0, "show_005");
`endif
            end else begin
                push_show(tab[i], "show_model");
            end
            step();
            load = 1'b0;
            step();
            x = sb.pop_front();
            n_checks++;
            if ({HEX2, HEX1, HEX0, valid, err} !== {x.h2, x.h1, x.h0, x.v, x.e}) begin
                n_fail++;
                $display("FAIL %s vec=%h: got h2=%b h1=%b h0=%b v=%b e=%b want h2=%b h1=%b h0=%b v=%b e=%b",
                         x.name, tab[i], HEX2, HEX1, HEX0, valid, err, x.h2, x.h1, x.h0, x.v, x.e);
            end
        end
    endtask

    task automatic test_error();
        exp_t x;
        for (int pass = 0; pass < 3; pass++) begin
            // Pass 0 enters ERROR, pass 1 re-enters it from ERROR, pass 2 leaves to SHOW.
            vec  = (pass == 0) ? 9'h0A3 : (pass == 1) ? 9'h0F0 : 9'h042;
            load = 1'b1;
            step();
            load = 1'b0;
            if (pass < 2) begin
                for (int i = 0; i < 12; i++)
                    push_exp(Blank, Blank, SegE, 1'b0, ((i / BlinkDiv) % 2) == 0, "err_blink");
            end else begin
                push_show(9'h042, "err_to_show");
            end
            for (int i = 0; i < ((pass < 2) ? 10 : 1); i++) begin
                step();
                x = sb.pop_front();
                n_checks++;
                if ({HEX2, HEX1, HEX0, valid, err} !== {x.h2, x.h1, x.h0, x.v, x.e}) begin
                    n_fail++;
                    $display("FAIL %s p%0d c%0d: got h2=%b h1=%b h0=%b v=%b e=%b want h2=%b h1=%b h0=%b v=%b e=%b",
                             x.name, pass, i, HEX2, HEX1, HEX0, valid, err, x.h2, x.h1, x.h0, x.v,
                             x.e);
                end
            end
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        load = 1'b0;
        step();
        vec  = 9'h011;
        load = 1'b1;
        step();
        vec = 9'h099;
        for (int i = 0; i < 9; i++) push_show(9'h011, "hold_load");
        for (int i = 0; i < 9; i++) begin
            step();
            x = sb.pop_front();
            n_checks++;
            if ({HEX2, HEX1, HEX0, valid, err} !== {x.h2, x.h1, x.h0, x.v, x.e}) begin
                n_fail++;
                $display("FAIL %s c%0d: got h2=%b h1=%b h0=%b v=%b e=%b want h2=%b h1=%b h0=%b v=%b e=%b",
                         x.name, i, HEX2, HEX1, HEX0, valid, err, x.h2, x.h1, x.h0, x.v, x.e);
            end
        end
        load = 1'b0;
        step();
        load = 1'b1;
        push_show(9'h099, "reraise_load");
        step();
        step();
        x = sb.pop_front();
        n_checks++;
        if ({HEX2, HEX1, HEX0, valid, err} !== {x.h2, x.h1, x.h0, x.v, x.e}) begin
            n_fail++;
            $display("FAIL %s: got h2=%b h1=%b h0=%b v=%b e=%b want h2=%b h1=%b h0=%b v=%b e=%b",
                     x.name, HEX2, HEX1, HEX0, valid, err, x.h2, x.h1, x.h0, x.v, x.e);
        end
    endtask

    task automatic test_reset_priority();
        exp_t x;
        load = 1'b0;
        step();
        reset_n = 1'b0;
        load    = 1'b1;
        vec     = 9'h150;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) push_exp(Blank, Blank, Blank, 1'b0, 1'b0, "reset_prio");
        for (int i = 0; i < 3; i++) begin
            step();
            x = sb.pop_front();
            n_checks++;
            if ({HEX2, HEX1, HEX0, valid, err} !== {x.h2, x.h1, x.h0, x.v, x.e}) begin
                n_fail++;
                $display("FAIL %s c%0d: got h2=%b h1=%b h0=%b v=%b e=%b want h2=%b h1=%b h0=%b v=%b e=%b",
                         x.name, i, HEX2, HEX1, HEX0, valid, err, x.h2, x.h1, x.h0, x.v, x.e);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        load    = 1'b1;
        vec     = '0;
        test_reset();
        test_show();
        test_error();
        test_back_to_back();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
